// File: rtl/writeback_unit_if.sv
// writeback_unit_if: retire, load-response, register-file write and hazard signals of the writeback stage
interface writeback_unit_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic [1:0]       in_wb_sel;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic             rf_en;
  logic [4:0]       rf_rd;
  logic [XLEN-1:0]  rf_wdata;
  logic             pend_valid;
  logic [4:0]       pend_rd;
  logic             err;
  logic [CNT_W-1:0] retire_count;
  modport slave (
    input  in_valid, in_rd, in_wb_sel, in_funct3, in_alu, in_pc, in_imm, mem_rvalid, mem_rdata,
    output in_ready, rf_en, rf_rd, rf_wdata, pend_valid, pend_rd, err, retire_count
  );
  modport master (
    output in_valid, in_rd, in_wb_sel, in_funct3, in_alu, in_pc, in_imm, mem_rvalid, mem_rdata,
    input  in_ready, rf_en, rf_rd, rf_wdata, pend_valid, pend_rd, err, retire_count
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: RV32I writeback stage selecting ALU/load/PC+4/imm data and driving the register-file write port
module writeback_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic rst,
  writeback_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_MEM = 2'd1, WRITE = 2'd2;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0]      state;
  logic [TW-1:0]   cnt;
  logic [4:0]      rd;
  logic [2:0]      f3;
  logic [1:0]      off;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [XLEN-1:0] ld, op;
  logic            is_mem, bad;
  assign bus.in_ready = state == IDLE;
  // load extraction from the captured offset, plus non-load data select and load legality of the incoming op
  always_comb begin
    lb = bus.mem_rdata[{off, 3'b000} +: 8];
    lh = bus.mem_rdata[{off[1], 4'b0000} +: 16];
    ld = f3[1] ? bus.mem_rdata
       : f3[0] ? {{(XLEN-16){~f3[2] & lh[15]}}, lh}
       : {{(XLEN-8){~f3[2] & lb[7]}}, lb};
    op = bus.in_wb_sel == 2'b00 ? bus.in_alu
       : bus.in_wb_sel == 2'b10 ? bus.in_pc + XLEN'(4)
       : bus.in_imm;
    is_mem = bus.in_wb_sel == 2'b01;
    bad = bus.in_funct3 == 3'b011 || bus.in_funct3[2:1] == 2'b11
       || (bus.in_funct3[1:0] == 2'b01 && bus.in_alu[0])
       || (bus.in_funct3 == 3'b010 && bus.in_alu[1:0] != 2'b00);
  end
  // FSM: accept in IDLE, wait for load data with a timeout, then one write cycle; x0 is never written
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rd <= '0;
      f3 <= '0;
      off <= '0;
      bus.rf_en <= 1'b0;
      bus.rf_rd <= '0;
      bus.rf_wdata <= '0;
      bus.pend_valid <= 1'b0;
      bus.pend_rd <= '0;
      bus.err <= 1'b0;
      bus.retire_count <= '0;
    end else begin
      bus.rf_en <= 1'b0;
      bus.err <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          rd <= bus.in_rd;
          f3 <= bus.in_funct3;
          off <= bus.in_alu[1:0];
          cnt <= '0;
          if (!is_mem || !bad) begin
            bus.pend_valid <= |bus.in_rd;
            bus.pend_rd <= bus.in_rd;
          end
          if (!is_mem) begin
            state <= WRITE;
            bus.rf_en <= |bus.in_rd;
            if (|bus.in_rd) begin
              bus.rf_rd <= bus.in_rd;
              bus.rf_wdata <= op;
              bus.retire_count <= bus.retire_count + CNT_W'(1);
            end
          end else if (bad) bus.err <= 1'b1;
          else state <= WAIT_MEM;
        end
        WAIT_MEM: if (bus.mem_rvalid) begin
          state <= WRITE;
          bus.rf_en <= |rd;
          if (|rd) begin
            bus.rf_rd <= rd;
            bus.rf_wdata <= ld;
            bus.retire_count <= bus.retire_count + CNT_W'(1);
          end
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          state <= IDLE;
          bus.err <= 1'b1;
          bus.pend_valid <= 1'b0;
        end else cnt <= cnt + TW'(1);
        WRITE: begin
          state <= IDLE;
          bus.pend_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized and directed checks of writeback_unit against a transaction-level model
module tb_writeback_unit;
  localparam int TIMEOUT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_cnt = 0;
  logic [31:0] m_rd = 0;
  logic [31:0] m_wd = 0;
  writeback_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
  writeback_unit #(.XLEN(32), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // one instruction end to end; called just after a falling edge with the unit idle
  task automatic run_op(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rdata, input int dly);
    logic ld, bad;
    int sz;
    logic [31:0] ev;
    ld = sel == 2'b01;
    sz = f3 % 4 == 0 ? 1 : f3 % 4 == 1 ? 2 : 4;
    bad = ld && (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || alu % sz != 0);
    ev = sel == 2'b00 ? alu : sel == 2'b10 ? pc + 32'd4 : imm;
    if (ld) begin
      ev = rdata >> (8 * (alu % 4));
      if (sz < 4) begin
        ev = ev % (32'd1 << (8 * sz));
        if (f3 < 4 && ev >= (32'd1 << (8 * sz - 1))) ev = ev - (32'd1 << (8 * sz));
      end
    end
    chk("ready idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_rd = rd;
    bus.in_wb_sel = sel;
    bus.in_funct3 = f3;
    bus.in_alu = alu;
    bus.in_pc = pc;
    bus.in_imm = imm;
    bus.mem_rvalid = 1'($urandom % 2);
    bus.mem_rdata = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.in_alu = $urandom;
    bus.in_rd = 5'($urandom);
    if (bad) begin
      chk("err", bus.err, 1);
      chk("rf_en on err", bus.rf_en, 0);
      chk("pend on err", bus.pend_valid, 0);
      chk("ready on err", bus.in_ready, 1);
      chk("count on err", bus.retire_count, m_cnt);
      @(negedge clk);
      chk("err pulse", bus.err, 0);
      return;
    end
    if (ld) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        chk("ready wait", bus.in_ready, 0);
        chk("pend wait", bus.pend_valid, rd != 0);
        if (rd != 0) chk("pend_rd wait", bus.pend_rd, rd);
        chk("rf_en wait", bus.rf_en, 0);
        chk("err wait", bus.err, 0);
        bus.mem_rvalid = k == dly;
        bus.mem_rdata = k == dly ? rdata : $urandom;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        if (k == dly) break;
      end
      if (dly >= TIMEOUT) begin
        chk("timeout err", bus.err, 1);
        chk("timeout rf_en", bus.rf_en, 0);
        chk("timeout ready", bus.in_ready, 1);
        chk("timeout pend", bus.pend_valid, 0);
        chk("timeout count", bus.retire_count, m_cnt);
        @(negedge clk);
        chk("timeout err pulse", bus.err, 0);
        return;
      end
    end
    if (rd != 0) begin
      m_cnt++;
      m_rd = rd;
      m_wd = ev;
    end
    chk("rf_en", bus.rf_en, rd != 0);
    chk("rf_rd", bus.rf_rd, m_rd);
    chk("rf_wdata", bus.rf_wdata, m_wd);
    chk("retire_count", bus.retire_count, m_cnt);
    chk("pend write", bus.pend_valid, rd != 0);
    chk("ready write", bus.in_ready, 0);
    chk("err write", bus.err, 0);
    @(negedge clk);
    chk("ready after", bus.in_ready, 1);
    chk("rf_en after", bus.rf_en, 0);
    chk("pend after", bus.pend_valid, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " rf_en"}, bus.rf_en, 0);
    chk({tag, " rf_rd"}, bus.rf_rd, 0);
    chk({tag, " rf_wdata"}, bus.rf_wdata, 0);
    chk({tag, " pend_valid"}, bus.pend_valid, 0);
    chk({tag, " pend_rd"}, bus.pend_rd, 0);
    chk({tag, " err"}, bus.err, 0);
    chk({tag, " retire_count"}, bus.retire_count, 0);
    chk({tag, " in_ready"}, bus.in_ready, 1);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_rd = '0;
    bus.in_wb_sel = '0;
    bus.in_funct3 = '0;
    bus.in_alu = '0;
    bus.in_pc = '0;
    bus.in_imm = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    run_op(5'd5, 2'b00, 3'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 0);
    chk("first retire", m_cnt, 1);
    run_op(5'd1, 2'b10, 3'd0, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h0, 0);
    run_op(5'd2, 2'b11, 3'd0, 32'h0, 32'h0, 32'h12345000, 32'h0, 0);
    run_op(5'd3, 2'b01, 3'd0, 32'h3, 32'h0, 32'h0, 32'h80F07F81, 0);
    run_op(5'd4, 2'b01, 3'd4, 32'h0, 32'h0, 32'h0, 32'h80F07F81, 1);
    run_op(5'd6, 2'b01, 3'd1, 32'h2, 32'h0, 32'h0, 32'h80F07F81, 3);
    run_op(5'd7, 2'b01, 3'd5, 32'h0, 32'h0, 32'h0, 32'h80F07F81, 0);
    run_op(5'd8, 2'b01, 3'd2, 32'h0, 32'h0, 32'h0, 32'h80F07F81, 2);
    run_op(5'd9, 2'b01, 3'd2, 32'h2, 32'h0, 32'h0, 32'h80F07F81, 0);
    run_op(5'd9, 2'b01, 3'd3, 32'h0, 32'h0, 32'h0, 32'h80F07F81, 0);
    run_op(5'd10, 2'b01, 3'd2, 32'h0, 32'h0, 32'h0, 32'h80F07F81, 9);
    run_op(5'd0, 2'b00, 3'd0, 32'h55AA55AA, 32'h0, 32'h0, 32'h0, 0);
    run_op(5'd0, 2'b01, 3'd2, 32'h0, 32'h0, 32'h0, 32'h11223344, 1);
    for (int i = 0; i < 300; i++)
      run_op($urandom % 8 == 0 ? 5'd0 : 5'($urandom), 2'($urandom), 3'($urandom), $urandom,
             $urandom % 4 == 0 ? 32'hFFFFFFFC : $urandom, $urandom, $urandom, int'($urandom % 6));
    bus.in_valid = 1'b1;
    bus.in_rd = 5'd7;
    bus.in_wb_sel = 2'b01;
    bus.in_funct3 = 3'd2;
    bus.in_alu = 32'h0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid-op pend", bus.pend_valid, 1);
    #2 rst = 1'b0;
    #1 chk_zero("async reset");
    @(negedge clk);
    rst = 1'b1;
    m_cnt = 0;
    m_rd = 0;
    m_wd = 0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    repeat (2) begin
      @(negedge clk);
      chk_zero("after reset");
    end
    bus.mem_rvalid = 1'b0;
    run_op(5'd12, 2'b00, 3'd0, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
